logic_unit_arbiter: RTL and testbench

Controller that shares one combinational 32-bit logic unit between two requesters. Op encoding: 00 XOR, 01 NOT A, 10 AND, 11 OR.
Round-robin arbitration with valid/ready handshake on each request port. Operands and op are registered and driven to the unit; the result is captured and returned on a single response channel tagged with the requester ID.
Sits between the control/issue logic and the shared logic unit in the datapath.

---
 rtl/logic_unit_arbiter.sv | 143 ++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one combinational logic unit between two requesters.
// Optional macro LU_ZERO_FLAG_EN adds a registered rsp_zero flag alongside rsp_data.
module logic_unit_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    output logic [1:0]       lu_op,
    input  logic [WIDTH-1:0] lu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id
`ifdef LU_ZERO_FLAG_EN
    ,
    output logic             rsp_zero
`endif
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q, state_d;
    logic              prio_q, prio_d;
    logic [WIDTH-1:0]  lu_a_q, lu_a_d;
    logic [WIDTH-1:0]  lu_b_q, lu_b_d;
    logic [1:0]        lu_op_q, lu_op_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic              rsp_id_q, rsp_id_d;
`ifdef LU_ZERO_FLAG_EN
    logic              rsp_zero_q, rsp_zero_d;
`endif

    logic grant;
    logic any_valid;

    // Priority holder wins if valid, otherwise fall back to the other requester.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (prio_q ? req1_valid : req0_valid) begin
            grant = prio_q;
        end else begin
            grant = ~prio_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        lu_a_d      = lu_a_q;
        lu_b_d      = lu_b_q;
        lu_op_d     = lu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
`ifdef LU_ZERO_FLAG_EN
        rsp_zero_d  = rsp_zero_q;
`endif
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (any_valid && !rst) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    lu_a_d     = grant ? req1_a  : req0_a;
                    lu_b_d     = grant ? req1_b  : req0_b;
                    lu_op_d    = grant ? req1_op : req0_op;
                    rsp_id_d   = grant;
                    prio_d     = ~grant;
                    state_d    = StExec;
                end
            end
            StExec: begin
                rsp_data_d  = lu_result;
                rsp_valid_d = 1'b1;
`ifdef LU_ZERO_FLAG_EN
                rsp_zero_d  = (lu_result == '0);
`endif
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            prio_q      <= 1'b0;
            lu_a_q      <= '0;
            lu_b_q      <= '0;
            lu_op_q     <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
`ifdef LU_ZERO_FLAG_EN
            rsp_zero_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            lu_a_q      <= lu_a_d;
            lu_b_q      <= lu_b_d;
            lu_op_q     <= lu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
`ifdef LU_ZERO_FLAG_EN
            rsp_zero_q  <= rsp_zero_d;
`endif
        end
    end

    assign lu_a      = lu_a_q;
    assign lu_b      = lu_b_q;
    assign lu_op     = lu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
`ifdef LU_ZERO_FLAG_EN
    assign rsp_zero  = rsp_zero_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: directed test-plan steps plus randomized transactions
// checked against a transaction-level model of arbitration, timing and the logic unit.
module tb_logic_unit_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic [1:0]       req0_op;
    logic             req1_valid, req1_ready;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] lu_a, lu_b, lu_result;
    logic [1:0]       lu_op;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH-1:0] rsp_data;
`ifdef LU_ZERO_FLAG_EN
    logic             rsp_zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit m_prio;  // model: requester that wins the next contention

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] lu_ref(input logic [WIDTH-1:0] a, b,
                                                input logic [1:0] op);
        case (op)
            2'b00:   return a ^ b;
            2'b01:   return ~a;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    // The shared combinational unit lives in the bench.
    assign lu_result = lu_ref(lu_a, lu_b, lu_op);

    logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .lu_a       (lu_a),
        .lu_b       (lu_b),
        .lu_op      (lu_op),
        .lu_result  (lu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
`ifdef LU_ZERO_FLAG_EN
        ,
        .rsp_zero   (rsp_zero)
`endif
    );

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from IDLE; loser (if any) stays valid throughout.
    task automatic txn(input bit v0, input bit v1,
                       input logic [WIDTH-1:0] a0, b0, input logic [1:0] op0,
                       input logic [WIDTH-1:0] a1, b1, input logic [1:0] op1,
                       input int hold, output logic [WIDTH-1:0] data, output bit gid);
        bit               g;
        logic [WIDTH-1:0] exp, ea, eb;
        logic [1:0]       eop;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp_ready  = 1'b0;
        #1;
        g   = (m_prio ? v1 : v0) ? m_prio : ~m_prio;
        ea  = g ? a1 : a0;
        eb  = g ? b1 : b0;
        eop = g ? op1 : op0;
        exp = lu_ref(ea, eb, eop);
        chk("accept_ready0", req0_ready, (v0 && g == 1'b0));
        chk("accept_ready1", req1_ready, (v1 && g == 1'b1));
        tick();
        m_prio = ~g;
        if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
        #1;
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_readies", {req1_ready, req0_ready}, 0);
        chk("exec_lu_a", lu_a, ea);
        chk("exec_lu_b", lu_b, eb);
        chk("exec_lu_op", lu_op, eop);
        tick();
        for (int i = 0; i <= hold; i++) begin
            chk("resp_valid", rsp_valid, 1);
            chk("resp_data", rsp_data, exp);
            chk("resp_id", rsp_id, g);
            chk("resp_readies", {req1_ready, req0_ready}, 0);
            chk("resp_lu_a_held", lu_a, ea);
`ifdef LU_ZERO_FLAG_EN
            chk("resp_zero", rsp_zero, (exp == '0));
`endif
            if (i < hold) tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("rsp_consumed", rsp_valid, 0);
        data = rsp_data;
        gid  = g;
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        bit               id;
        bit               rv0, rv1;

        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = '1; req0_b = '1; req0_op = 2'b11;
        req1_valid = 1'b1; req1_a = '1; req1_b = '1; req1_op = 2'b11;
        m_prio = 1'b0;

        // Reset: readies must stay low even with both requesters valid.
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            tick();
        end
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_lu_a", lu_a, 0);
        chk("rst_lu_b", lu_b, 0);
        chk("rst_lu_op", lu_op, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_readies", {req1_ready, req0_ready}, 0);
        end

        // Single XOR from req0.
        txn(1, 0, 32'hFFFF0000, 32'h0F0F0F0F, 2'b00, '0, '0, 2'b00, 0, d, id);
        chk("xor_data", d, 32'hF0F00F0F);
        chk("xor_id", id, 0);

        // Prio is now 1; idle cycles must not change it.
        repeat (3) tick();
        txn(1, 1, 32'h12345678, 32'h0, 2'b01, 32'hF0F0F0F0, 32'hFF00FF00, 2'b10, 0, d, id);
        chk("cont_first_id", id, 1);
        chk("cont_first_data", d, 32'hF000F000);
        txn(1, 0, 32'h12345678, 32'h0, 2'b01, '0, '0, 2'b00, 0, d, id);
        chk("cont_second_id", id, 0);
        chk("cont_second_data", d, 32'hEDCBA987);

        // Back-pressure with req0 waiting; req0 accepted right after rsp handshake.
        txn(1, 1, 32'h11111111, 32'h22222222, 2'b11, 32'h0000FFFF, 32'hFFFF0000, 2'b11, 5, d, id);
        chk("bp_id", id, 1);
        chk("bp_data", d, 32'hFFFFFFFF);
        txn(1, 0, 32'h11111111, 32'h22222222, 2'b11, '0, '0, 2'b00, 0, d, id);
        chk("bp_resume_data", d, 32'h33333333);

        // Reset during EXEC: prio was 1, must return to 0 and no response appears.
        req0_valid = 1'b1; req0_a = 32'hDEADBEEF; req0_b = 32'h1; req0_op = 2'b10;
        #1;
        chk("mid_accept", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_lu_a", lu_a, 0);
        chk("mid_lu_op", lu_op, 0);
        chk("mid_rsp_data", rsp_data, 0);
        rst = 1'b0;
        m_prio = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_rsp", rsp_valid, 0);
        end
        txn(1, 1, 32'hAAAA5555, 32'h0, 2'b01, 32'h1, 32'h2, 2'b11, 0, d, id);
        chk("mid_prio_id", id, 0);
        chk("mid_prio_data", d, 32'h5555AAAA);

`ifdef LU_ZERO_FLAG_EN
        txn(1, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, '0, '0, 2'b00, 0, d, id);
        chk("zf_data", d, 0);
        chk("zf_flag_set", rsp_zero, 1);
        txn(0, 1, '0, '0, 2'b00, 32'h1, 32'h0, 2'b11, 0, d, id);
        chk("zf_flag_clr", rsp_zero, 0);
`endif

        // Randomized transactions against the model.
        for (int t = 0; t < 40; t++) begin
            rv0 = 1'($urandom_range(0, 1));
            rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
            txn(rv0, rv1, $urandom, $urandom, 2'($urandom_range(0, 3)),
                $urandom, $urandom, 2'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), d, id);
            req0_valid = 1'b0; req1_valid = 1'b0;
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
